// File: rtl/pipeline_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer, registered in_ready,
// synchronous flush and optional NOP masking of the control word on bubbles.
module pipeline_stage_skid #(
  parameter int CTRL_W      = 64,
  parameter int DATA_W      = 160,
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              ready_q;
  logic [1:0]        occ_q;

  logic accept, fire;
  logic main_valid_d, skid_valid_d;
  logic load_main_in, load_main_skid, load_skid;

  assign accept = in_valid & ready_q;
  assign fire   = main_valid & out_ready;

  // State is implied by the two valid bits: EMPTY, ONE (main only), FULL (both).
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    main_valid_d   = main_valid;
    skid_valid_d   = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_valid_d = 1'b1;
        load_main_in = 1'b1;
      end
    end else if (!skid_valid) begin
      if (accept && fire) begin
        load_main_in = 1'b1;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        load_skid    = 1'b1;
      end else if (fire) begin
        main_valid_d = 1'b0;
      end
    end else if (fire) begin
      skid_valid_d   = 1'b0;
      load_main_skid = 1'b1;
    end
  end

  // NOTE: payload registers sit under the async reset too, because a reset must
  // leave the presented word at zero even with BUBBLE_ZERO=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      ready_q    <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
      ready_q <= !(main_valid_d && skid_valid_d);
      occ_q   <= {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = occ_q;
  assign out_ctrl  = (BUBBLE_ZERO && !main_valid) ? '0 : main_ctrl;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: queue-based reference model checked every cycle,
// two instances (BUBBLE_ZERO=1 and 0) driven in lockstep, plus literal spot checks.
module tb_pipeline_stage_skid;

  localparam int CW = 64;
  localparam int DW = 160;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;

  int errors = 0;
  int checks = 0;

  word_t q[$];
  logic  m_ready = 1'b0;
  word_t m_main  = '0;

  always #5 clk = ~clk;

  pipeline_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_ZERO(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0)
  );

  pipeline_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_ZERO(1'b0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [CW-1:0] masked;
    masked = (q.size() > 0) ? m_main.c : '0;
    check("out_valid",  {255'd0, out_valid0}, {255'd0, q.size() > 0});
    check("in_ready",   {255'd0, in_ready0},  {255'd0, m_ready});
    check("occupancy",  {254'd0, occ0},       256'(q.size()));
    check("out_ctrl",   256'(out_ctrl0),      256'(masked));
    check("out_data",   256'(out_data0),      256'(m_main.d));
    check("raw_valid",  {255'd0, out_valid1}, {255'd0, q.size() > 0});
    check("raw_ready",  {255'd0, in_ready1},  {255'd0, m_ready});
    check("raw_ctrl",   256'(out_ctrl1),      256'(m_main.c));
    check("raw_data",   256'(out_data1),      256'(m_main.d));
  endtask

  // Advance one clock: the model applies the FIFO rules, then outputs are compared
  // at the following falling edge. Returns whether the offered word was taken.
  task automatic cycle(output bit acc);
    bit fr;
    word_t w;
    acc = in_valid && m_ready;
    fr  = (q.size() > 0) && out_ready;
    w   = '{c: in_ctrl, d: in_data};
    @(posedge clk);
    if (flush) begin
      q.delete();
      acc = 1'b0;
    end else begin
      if (fr) void'(q.pop_front());
      if (acc) q.push_back(w);
    end
    m_ready = (q.size() != 2);
    if (q.size() > 0) m_main = q[0];
    @(negedge clk);
    compare_all();
  endtask

  task automatic offer(input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = {c[31:0], ~c[31:0], c[31:0] ^ 32'h5a5a_a5a5, 64'hdead_beef_0000_0000 | 64'(c)};
  endtask

  initial begin
    bit acc;
    logic [CW-1:0] next_c;

    // Power-on reset, then release.
    repeat (2) @(negedge clk);
    check("por_in_ready", {255'd0, in_ready0}, 256'd0);
    check("por_occ", {254'd0, occ0}, 256'd0);
    rst = 1'b1;
    cycle(acc);
    check("release_ready", {255'd0, in_ready0}, 256'd1);

    // Streaming 1..8 with out_ready held high.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      offer(CW'(k));
      cycle(acc);
      check("stream_ctrl", 256'(out_ctrl0), 256'(k));
      check("stream_ready", {255'd0, in_ready0}, 256'd1);
    end
    in_valid = 1'b0;
    cycle(acc);

    // Backpressure with A, B, C offered.
    out_ready = 1'b0;
    offer(64'hA); cycle(acc);
    offer(64'hB); cycle(acc);
    offer(64'hC); cycle(acc);
    check("bp_occ", {254'd0, occ0}, 256'd2);
    check("bp_ready", {255'd0, in_ready0}, 256'd0);
    check("bp_ctrl_A", 256'(out_ctrl0), 256'hA);
    cycle(acc);
    check("bp_stable_A", 256'(out_ctrl0), 256'hA);
    out_ready = 1'b1;
    cycle(acc);
    check("bp_order_B", 256'(out_ctrl0), 256'hB);
    cycle(acc);
    check("bp_order_C", 256'(out_ctrl0), 256'hC);
    in_valid = 1'b0;
    cycle(acc);
    check("bp_drained", {254'd0, occ0}, 256'd0);

    // Flush while FULL, with D offered in the same cycle.
    out_ready = 1'b0;
    offer(64'hE); cycle(acc);
    offer(64'hF); cycle(acc);
    check("pre_flush_occ", {254'd0, occ0}, 256'd2);
    flush = 1'b1;
    offer(64'hD);
    cycle(acc);
    check("flush_occ", {254'd0, occ0}, 256'd0);
    check("flush_valid", {255'd0, out_valid0}, 256'd0);
    check("flush_ctrl", 256'(out_ctrl0), 256'd0);
    check("flush_ready", {255'd0, in_ready0}, 256'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle(acc);
    check("no_D", {255'd0, out_valid0}, 256'd0);
    check("flush_keeps_payload", 256'(out_ctrl1), 256'hE);

    // Simultaneous accept and fire in ONE.
    out_ready = 1'b0;
    offer(64'h11); cycle(acc);
    out_ready = 1'b1;
    offer(64'h22); cycle(acc);
    check("af_ctrl_Y", 256'(out_ctrl0), 256'h22);
    check("af_occ", {254'd0, occ0}, 256'd1);

    // Drain: raw instance keeps the last word, masked one shows a NOP.
    in_valid = 1'b0;
    cycle(acc);
    check("drain_masked", 256'(out_ctrl0), 256'd0);
    check("drain_raw", 256'(out_ctrl1), 256'h22);

    // Mixed traffic with irregular backpressure.
    next_c = 64'h100;
    offer(next_c);
    for (int i = 0; i < 48; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) begin
        next_c++;
        offer(next_c);
        in_valid = ($urandom_range(0, 3) != 0);
      end
    end

    // Asynchronous reset mid-stream with two words held.
    out_ready = 1'b0;
    offer(64'h77); cycle(acc);
    offer(64'h88); cycle(acc);
    offer(64'h99); cycle(acc);
    check("pre_rst_occ", {254'd0, occ0}, 256'd2);
    #2 rst = 1'b0;
    #1;
    q.delete();
    m_ready = 1'b0;
    m_main  = '0;
    check("rst_valid", {255'd0, out_valid0}, 256'd0);
    check("rst_ctrl", 256'(out_ctrl0), 256'd0);
    check("rst_raw_ctrl", 256'(out_ctrl1), 256'd0);
    check("rst_occ", {254'd0, occ0}, 256'd0);
    check("rst_ready", {255'd0, in_ready0}, 256'd0);
    @(negedge clk);
    compare_all();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle(acc);
    check("rst_release_ready", {255'd0, in_ready0}, 256'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
